// File: rtl/chiplet_link_tx.sv
// chiplet_link_tx: serialises router egress flits into PHIT_W-wide link beats
// under per-VC credit flow control. Optional macro LINK_PARITY_EN adds the
// phit_parity_o output (XOR of each beat).

package noc_params;
    parameter int VC_NUM = 2;
endpackage

module chiplet_link_tx #(
    parameter int FLIT_W      = 64,
    parameter int PHIT_W      = 16,
    parameter int VC_NUM      = noc_params::VC_NUM,
    parameter int BUFFER_SIZE = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flit_valid_i,
    input  logic [FLIT_W-1:0]          flit_data_i,
    input  logic [$clog2(VC_NUM)-1:0]  flit_vc_i,
    output logic                       flit_ready_o,
    input  logic                       credit_valid_i,
    input  logic [$clog2(VC_NUM)-1:0]  credit_vc_i,
    output logic                       phit_valid_o,
    output logic [PHIT_W-1:0]          phit_data_o,
    output logic                       phit_head_o,
`ifdef LINK_PARITY_EN
    output logic                       phit_parity_o,
`endif
    output logic [$clog2(VC_NUM)-1:0]  phit_vc_o,
    output logic [VC_NUM-1:0]          credit_avail_o,
    output logic [VC_NUM-1:0]          error_o
);

    localparam int NB = FLIT_W / PHIT_W;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int VW = $clog2(VC_NUM);
    localparam int CW = $clog2(BUFFER_SIZE + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);
    localparam logic [CW-1:0] FULL      = CW'(BUFFER_SIZE);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state, state_nxt;
    logic [BW-1:0]       beat_p1, beat_nxt;
    logic [FLIT_W-1:0]   flit_p1;
    logic [VW-1:0]       vc_p1;
    logic [CW-1:0]       cnt [VC_NUM];
    logic [VC_NUM-1:0]   err;
    logic [VC_NUM-1:0]   inc_v, dec_v;
    logic                last_beat, accept;

    // A new flit may be taken when the link is idle or finishing its last beat.
    assign last_beat    = (state == SEND) && (beat_p1 == LAST_BEAT);
    assign flit_ready_o = !rst && ((state == IDLE) || last_beat) && (cnt[flit_vc_i] != '0);
    assign accept       = flit_valid_i && flit_ready_o;

    // Next-state and beat-counter logic; an accept always restarts at beat 0.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_p1;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SEND;
                    beat_nxt  = '0;
                end
            end
            SEND: begin
                if (last_beat) begin
                    beat_nxt = '0;
                    if (!accept) state_nxt = IDLE;
                end else begin
                    beat_nxt = beat_p1 + 1'b1;
                end
            end
        endcase
    end

    // State register; reset aborts any flit in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            beat_p1 <= '0;
            vc_p1   <= '0;
        end else begin
            state   <= state_nxt;
            beat_p1 <= beat_nxt;
            if (accept) vc_p1 <= flit_vc_i;
        end
    end

    // Flit payload capture (stage p0 -> p1); data path carries no reset.
    always_ff @(posedge clk) begin
        if (accept) flit_p1 <= flit_data_i;
    end

    // Per-VC credit events decoded from the accept and credit-return inputs.
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            inc_v[v] = credit_valid_i && (credit_vc_i == VW'(v));
            dec_v[v] = accept && (flit_vc_i == VW'(v));
        end
    end

    // Credit counters: simultaneous take and return cancel; overflow saturates and sticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) cnt[v] <= FULL;
            err <= '0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (inc_v[v] && !dec_v[v]) begin
                    if (cnt[v] == FULL) err[v] <= 1'b1;
                    else                cnt[v] <= cnt[v] + 1'b1;
                end else if (dec_v[v] && !inc_v[v]) begin
                    cnt[v] <= cnt[v] - 1'b1;
                end
            end
        end
    end

    // Credit availability flags.
    always_comb begin
        credit_avail_o = '0;
        for (int v = 0; v < VC_NUM; v++) credit_avail_o[v] = (cnt[v] != '0);
    end

    // Beat k of the held flit is selected straight from registers.
    assign phit_valid_o = (state == SEND);
    assign phit_head_o  = (state == SEND) && (beat_p1 == '0);
    assign phit_data_o  = phit_valid_o ? flit_p1[beat_p1*PHIT_W +: PHIT_W] : '0;
    assign phit_vc_o    = vc_p1;
    assign error_o      = err;

`ifdef LINK_PARITY_EN
    assign phit_parity_o = ^phit_data_o;
`endif

endmodule

// File: tb/tb_chiplet_link_tx.sv
// Self-checking bench for chiplet_link_tx: directed scenarios plus a random
// phase, all checked against a beat-queue / credit-count reference model.

module tb_chiplet_link_tx;

    localparam int FLIT_W = 64;
    localparam int PHIT_W = 16;
    localparam int VC_NUM = 2;
    localparam int BUFFER_SIZE = 8;
    localparam int NB = FLIT_W / PHIT_W;

    logic              clk;
    logic              rst;
    logic              flit_valid;
    logic [FLIT_W-1:0] flit_data;
    logic              flit_vc;
    logic              flit_ready;
    logic              credit_valid;
    logic              credit_vc;
    logic              phit_valid;
    logic [PHIT_W-1:0] phit_data;
    logic              phit_head;
    logic              phit_vc;
    logic [1:0]        credit_avail;
    logic [1:0]        error;
`ifdef LINK_PARITY_EN
    logic              phit_parity;
`endif

    chiplet_link_tx #(
        .FLIT_W(FLIT_W), .PHIT_W(PHIT_W), .VC_NUM(VC_NUM), .BUFFER_SIZE(BUFFER_SIZE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flit_valid_i(flit_valid),
        .flit_data_i(flit_data),
        .flit_vc_i(flit_vc),
        .flit_ready_o(flit_ready),
        .credit_valid_i(credit_valid),
        .credit_vc_i(credit_vc),
        .phit_valid_o(phit_valid),
        .phit_data_o(phit_data),
        .phit_head_o(phit_head),
`ifdef LINK_PARITY_EN
        .phit_parity_o(phit_parity),
`endif
        .phit_vc_o(phit_vc),
        .credit_avail_o(credit_avail),
        .error_o(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of beats still to appear on the link, credits, errors.
    typedef struct {
        logic [PHIT_W-1:0] data;
        logic              head;
        logic              vc;
    } beat_t;

    beat_t q[$];
    int    cred[VC_NUM];
    logic [1:0] merr;
    logic  mvc;
    int    ntests;
    int    nfail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int v = 0; v < VC_NUM; v++) cred[v] = BUFFER_SIZE;
        merr = '0;
        mvc  = 1'b0;
    endtask

    // One clock: compare outputs at negedge, advance model at posedge.
    task automatic cycle();
        logic              exp_ready;
        logic              ev;
        logic [PHIT_W-1:0] ed;
        logic              eh;
        logic [1:0]        avail;
        beat_t             b;
        @(negedge clk);
        exp_ready = !rst && (q.size() <= 1) && (cred[flit_vc] != 0);
        ev = (q.size() != 0);
        ed = ev ? q[0].data : '0;
        eh = ev ? q[0].head : 1'b0;
        for (int v = 0; v < VC_NUM; v++) avail[v] = (cred[v] != 0);
        check("ready", flit_ready, exp_ready);
        check("valid", phit_valid, ev);
        check("data", phit_data, ed);
        check("head", phit_head, eh);
        check("vc", phit_vc, mvc);
        check("avail", credit_avail, avail);
        check("error", error, merr);
`ifdef LINK_PARITY_EN
        check("parity", phit_parity, ^ed);
`endif
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (q.size() != 0) void'(q.pop_front());
            if (flit_valid && exp_ready) begin
                for (int k = 0; k < NB; k++) begin
                    b.data = flit_data[k*PHIT_W +: PHIT_W];
                    b.head = (k == 0);
                    b.vc   = flit_vc;
                    q.push_back(b);
                end
                cred[flit_vc]--;
                mvc = flit_vc;
            end
            if (credit_valid) begin
                if (cred[credit_vc] == BUFFER_SIZE) merr[credit_vc] = 1'b1;
                else                                cred[credit_vc]++;
            end
        end
        #1;
    endtask

    int nvalid;

    initial begin
        ntests = 0;
        nfail  = 0;
        rst = 1'b1;
        flit_valid = 1'b0;
        flit_data = '0;
        flit_vc = 1'b0;
        credit_valid = 1'b0;
        credit_vc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cycle();
        check("rst_ready", flit_ready, 1'b0);
        rst = 1'b0;
        cycle();

        // Single flit on VC0: four beats, low half-word first.
        flit_valid = 1'b1;
        flit_vc = 1'b0;
        flit_data = 64'h0123_4567_89AB_CDEF;
        cycle();
        flit_valid = 1'b0;
        check("f0_b0_data", phit_data, 16'hCDEF);
        check("f0_b0_head", phit_head, 1'b1);
        cycle();
        check("f0_b1_data", phit_data, 16'h89AB);
        check("f0_b1_head", phit_head, 1'b0);
        cycle();
        check("f0_b2_data", phit_data, 16'h4567);
        cycle();
        check("f0_b3_data", phit_data, 16'h0123);
        cycle();
        check("f0_idle", phit_valid, 1'b0);

        // Eight back-to-back VC1 flits exhaust VC1 credits.
        flit_valid = 1'b1;
        flit_vc = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 34; i++) begin
            flit_data = {$urandom, $urandom};
            cycle();
            if (phit_valid) nvalid++;
        end
        check("b2b_beats", nvalid, 32);
        check("b2b_avail", credit_avail, 2'b01);
        check("b2b_ready_vc1", flit_ready, 1'b0);
        flit_valid = 1'b0;
        credit_valid = 1'b1;
        credit_vc = 1'b1;
        cycle();
        credit_valid = 1'b0;
        flit_valid = 1'b1;
        #1;
        check("ready_after_credit", flit_ready, 1'b1);
        cycle();
        flit_valid = 1'b0;
        repeat (4) cycle();

        // Credit overflow on VC1: 8 returns refill it, the 9th overflows.
        credit_valid = 1'b1;
        credit_vc = 1'b1;
        repeat (9) cycle();
        credit_valid = 1'b0;
        check("ovf_error", error, 2'b10);
        check("ovf_avail", credit_avail, 2'b11);
        repeat (2) cycle();
        check("ovf_sticky", error, 2'b10);

        // Refill VC0 to full, then accept and return on VC0 in the same cycle.
        credit_valid = 1'b1;
        credit_vc = 1'b0;
        cycle();
        flit_valid = 1'b1;
        flit_vc = 1'b0;
        flit_data = {$urandom, $urandom};
        cycle();
        flit_valid = 1'b0;
        credit_valid = 1'b0;
        check("same_cycle_err", error, 2'b10);
        repeat (4) cycle();

        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_clears_err", error, 2'b00);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            flit_valid   = ($urandom_range(0, 3) != 0);
            flit_vc      = 1'($urandom_range(0, 1));
            flit_data    = {$urandom, $urandom};
            credit_valid = ($urandom_range(0, 4) == 0);
            credit_vc    = 1'($urandom_range(0, 1));
            cycle();
        end
        flit_valid = 1'b0;
        credit_valid = 1'b0;

        // Reset in the middle of a flit.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        flit_valid = 1'b1;
        flit_vc = 1'b1;
        flit_data = {$urandom, $urandom};
        cycle();
        flit_valid = 1'b0;
        cycle();
        cycle();
        check("mid_beat2_valid", phit_valid, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("abort_valid", phit_valid, 1'b0);
        check("abort_avail", credit_avail, 2'b11);
        flit_valid = 1'b1;
        flit_vc = 1'b0;
        flit_data = {$urandom, $urandom};
        cycle();
        flit_valid = 1'b0;
        check("fresh_head", phit_head, 1'b1);
        check("fresh_valid", phit_valid, 1'b1);
        repeat (5) cycle();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/chiplet_link_tx.md
CHIPLET_LINK_TX -- requirements
Module: chiplet_link_tx

Interface
REQ-001 SHALL have parameter FLIT_W, default 64, flit width in bits.
REQ-002 SHALL have parameter PHIT_W, default 16, link beat width; FLIT_W SHALL be an integer multiple of PHIT_W.
REQ-003 SHALL have parameter VC_NUM, default noc_params::VC_NUM, number of virtual channels.
REQ-004 SHALL have parameter BUFFER_SIZE, default 8, receiver buffer depth per VC, in flits.
REQ-005 SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 flit_valid_i  input  1  router egress flit present.
REQ-009 flit_data_i  input  FLIT_W  flit payload.
REQ-010 flit_vc_i  input  $clog2(VC_NUM)  flit VC.
REQ-011 flit_ready_o  output  1  flit accepted this cycle when high with flit_valid_i.
REQ-012 credit_valid_i  input  1  one credit returned by far die.
REQ-013 credit_vc_i  input  $clog2(VC_NUM)  VC of returned credit.
REQ-014 phit_valid_o  output  1  beat valid on link.
REQ-015 phit_data_o  output  PHIT_W  beat payload.
REQ-016 phit_head_o  output  1  first beat of a flit.
REQ-017 phit_vc_o  output  $clog2(VC_NUM)  VC of flit in flight.
REQ-018 credit_avail_o  output  VC_NUM  bit v high when VC v credit count is nonzero.
REQ-019 error_o  output  VC_NUM  sticky credit-overflow flag per VC.

Function
REQ-020 Beats per flit SHALL be NB = FLIT_W/PHIT_W; beat k SHALL carry flit bits [k*PHIT_W +: PHIT_W], k=0 first.
REQ-021 FSM SHALL have states IDLE and SEND; IDLE->SEND on accept; SEND stays until beat NB-1; at beat NB-1 it SHALL stay in SEND if a new flit is accepted that cycle, else go to IDLE.
REQ-022 flit_ready_o SHALL be high iff (state IDLE or beat NB-1 in SEND) and credit count of flit_vc_i is nonzero; it may depend combinationally on flit_vc_i.
REQ-023 Flit accepted in cycle N SHALL drive beat 0 (phit_head_o=1) in cycle N+1 from registers; beats SHALL be contiguous with no bubbles, including back-to-back flits.
REQ-024 phit_valid_o SHALL be high exactly in SEND; phit_head_o only on beat 0; phit_vc_o constant for a flit's beats.
REQ-025 Per-VC credit counter width $clog2(BUFFER_SIZE+1); accept SHALL decrement, credit_valid_i SHALL increment; both on same VC same cycle SHALL leave it unchanged.
REQ-026 Credit increment at count BUFFER_SIZE SHALL saturate and set error_o[vc]; error_o cleared only by rst.
REQ-027 A flit SHALL never be accepted at credit 0; NB=1 SHALL be supported (every SEND cycle is beat 0 and last beat).

Reset
REQ-028 On rst: state IDLE, beat counter 0, phit_valid_o=0, phit_head_o=0, phit_data_o=0, phit_vc_o=0, error_o=0, all counters=BUFFER_SIZE, credit_avail_o all ones.
REQ-029 rst during SEND SHALL abort the flit; phit_valid_o SHALL be 0 in the next cycle; no partial beats resume.
REQ-030 flit_ready_o SHALL be 0 while rst is high.

Configuration
REQ-031 With macro LINK_PARITY_EN defined, output phit_parity_o (1 bit) SHALL be present and equal even parity (XOR) of phit_data_o each beat, 0 when idle/reset; without it the port and logic SHALL be absent and behaviour otherwise identical.

Verification
REQ-032 Reset then one flit 0x0123_4567_89AB_CDEF VC0 -> cycles N+1..N+4 phits 0xCDEF,0x89AB,0x4567,0x0123, head on first only, credit VC0 = 7.
REQ-033 Eight back-to-back VC1 flits, no credits -> 32 contiguous valid beats, then flit_ready_o=0 for VC1, credit_avail_o=2'b01; one VC1 credit -> ready returns next cycle.
REQ-034 Accept on VC0 and credit_valid_i on VC0 same cycle -> VC0 count unchanged (8 stays 8 minus prior sends), error_o=0.
REQ-035 Credit returned to VC1 at count 8 -> count stays 8, error_o=2'b10 until rst.
REQ-036 rst asserted at beat 2 -> phit_valid_o=0 next cycle, counters 8, fresh flit after reset starts with head beat.
REQ-037 With LINK_PARITY_EN, phit 0xCDEF -> phit_parity_o=0; phit 0x0001 -> 1.
